// File: rtl/uifdma_ram_resp.sv
// FDMA responder backed by an internal single-port synchronous RAM.
// Serves one write or read burst at a time on the fdma_w*/fdma_r* interface.
//
// Ports:
//   ui_clk, ui_rstn          clock, async active-low reset
//   fdma_waddr/wareq/wsize   write request (byte address, beats)
//   fdma_wbusy               write burst in progress
//   fdma_wdata/wvalid/wready write beat (wvalid = responder can take a beat)
//   fdma_raddr/rareq/rsize   read request (byte address, beats)
//   fdma_rbusy               read burst in progress
//   fdma_rdata/rvalid/rready read beat
//   wr_burst_cnt/rd_burst_cnt completed burst counters
//
// Optional build macro UIFDMA_RESP_STALL_EN: an 8-bit LFSR randomly
// throttles write acceptance and RAM read issue (data and order unchanged).

module uifdma_ram_resp #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 128,
    parameter int MEM_DEPTH      = 4096
) (
    input  logic                      ui_clk,
    input  logic                      ui_rstn,
    input  logic [AXI_ADDR_WIDTH-1:0] fdma_waddr,
    input  logic                      fdma_wareq,
    input  logic [15:0]               fdma_wsize,
    output logic                      fdma_wbusy,
    input  logic [AXI_DATA_WIDTH-1:0] fdma_wdata,
    output logic                      fdma_wvalid,
    input  logic                      fdma_wready,
    input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
    input  logic                      fdma_rareq,
    input  logic [15:0]               fdma_rsize,
    output logic                      fdma_rbusy,
    output logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
    output logic                      fdma_rvalid,
    input  logic                      fdma_rready,
    output logic [31:0]               wr_burst_cnt,
    output logic [31:0]               rd_burst_cnt
);

    localparam int OFF_W = $clog2(AXI_DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RBURST,
        DONE
    } state_t;

    state_t                    state;
    logic                      dir_rd;
    logic                      last_rd;
    logic [IDX_W-1:0]          idx;
    logic [15:0]               wrem;
    logic [15:0]               irem;
    logic [15:0]               prem;
    logic                      wvalid_r;
    logic                      wbusy_r;
    logic                      rbusy_r;
    logic [31:0]               wcnt;
    logic [31:0]               rcnt;

    logic                      inflight;
    logic [1:0]                occ;
    logic [AXI_DATA_WIDTH-1:0] buf0;
    logic [AXI_DATA_WIDTH-1:0] buf1;
    logic [AXI_DATA_WIDTH-1:0] ram_q;
    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [IDX_W-1:0]          widx;
    logic [IDX_W-1:0]          ridx;
    logic                      stall_ok;
    logic                      take_w;
    logic                      take_r;
    logic                      wbeat;
    logic                      pop;
    logic                      push;
    logic                      issue;
    logic [2:0]                fill;

    assign widx = IDX_W'(fdma_waddr >> OFF_W);
    assign ridx = IDX_W'(fdma_raddr >> OFF_W);

`ifdef UIFDMA_RESP_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign stall_ok = lfsr[0];
`else
    assign stall_ok = 1'b1;
`endif

    // Arbitration: on a tie, serve the direction not served last.
    assign take_w = fdma_wareq && (!fdma_rareq || last_rd);
    assign take_r = fdma_rareq && !take_w;

    assign wbeat = (state == WBURST) && wvalid_r
                 && stall_ok && fdma_wready;

    assign pop  = (occ != 2'd0) && fdma_rready;
    assign push = inflight;

    // Buffer slots committed after this cycle; counting the pop keeps
    // one read per cycle in steady state.
    assign fill  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign issue = (state == RBURST) && (irem != 16'd0)
                 && stall_ok && (fill < 3'd2);

    always_ff @(posedge ui_clk) begin
        if (wbeat) begin
            mem[idx] <= fdma_wdata;
        end
        if (issue) begin
            ram_q <= mem[idx];
        end
    end

    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            state    <= IDLE;
            dir_rd   <= 1'b0;
            last_rd  <= 1'b1;
            idx      <= '0;
            wrem     <= '0;
            irem     <= '0;
            prem     <= '0;
            wvalid_r <= 1'b0;
            wbusy_r  <= 1'b0;
            rbusy_r  <= 1'b0;
            wcnt     <= '0;
            rcnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take_w) begin
                        dir_rd  <= 1'b0;
                        last_rd <= 1'b0;
                        wbusy_r <= 1'b1;
                        idx     <= widx;
                        wrem    <= fdma_wsize;
                        state   <= (fdma_wsize == 16'd0) ? DONE : WBURST;
                    end else if (take_r) begin
                        dir_rd  <= 1'b1;
                        last_rd <= 1'b1;
                        rbusy_r <= 1'b1;
                        idx     <= ridx;
                        irem    <= fdma_rsize;
                        prem    <= fdma_rsize;
                        state   <= (fdma_rsize == 16'd0) ? DONE : RBURST;
                    end
                end
                WBURST: begin
                    if (wbeat) begin
                        idx  <= idx + IDX_ONE;
                        wrem <= wrem - 16'd1;
                        if (wrem == 16'd1) begin
                            wvalid_r <= 1'b0;
                            state    <= DONE;
                        end
                    end else begin
                        wvalid_r <= 1'b1;
                    end
                end
                RBURST: begin
                    if (issue) begin
                        idx  <= idx + IDX_ONE;
                        irem <= irem - 16'd1;
                    end
                    if (pop) begin
                        prem <= prem - 16'd1;
                        if (prem == 16'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    wbusy_r <= 1'b0;
                    rbusy_r <= 1'b0;
                    if (dir_rd) begin
                        rcnt <= rcnt + 32'd1;
                    end else begin
                        wcnt <= wcnt + 32'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry output buffer; buf0 is the head presented on fdma_rdata.
    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            inflight <= 1'b0;
            occ      <= 2'd0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            inflight <= issue;
            occ      <= occ + {1'b0, push} - {1'b0, pop};
            if (push && pop) begin
                if (occ == 2'd1) begin
                    buf0 <= ram_q;
                end else begin
                    buf0 <= buf1;
                    buf1 <= ram_q;
                end
            end else if (pop) begin
                buf0 <= buf1;
            end else if (push) begin
                if (occ == 2'd0) begin
                    buf0 <= ram_q;
                end else begin
                    buf1 <= ram_q;
                end
            end
        end
    end

    assign fdma_wbusy   = wbusy_r;
    assign fdma_rbusy   = rbusy_r;
    assign fdma_wvalid  = wvalid_r & stall_ok;
    assign fdma_rvalid  = (occ != 2'd0);
    assign fdma_rdata   = buf0;
    assign wr_burst_cnt = wcnt;
    assign rd_burst_cnt = rcnt;

endmodule

// File: tb/tb_uifdma_ram_resp.sv
// Directed self-checking bench for uifdma_ram_resp.
// Linear stimulus with immediate assertions at each check point.

module tb_uifdma_ram_resp;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [31:0]  fdma_waddr = '0;
    logic         fdma_wareq = 1'b0;
    logic [15:0]  fdma_wsize = '0;
    logic         fdma_wbusy;
    logic [127:0] fdma_wdata = '0;
    logic         fdma_wvalid;
    logic         fdma_wready = 1'b0;
    logic [31:0]  fdma_raddr = '0;
    logic         fdma_rareq = 1'b0;
    logic [15:0]  fdma_rsize = '0;
    logic         fdma_rbusy;
    logic [127:0] fdma_rdata;
    logic         fdma_rvalid;
    logic         fdma_rready = 1'b0;
    logic [31:0]  wr_burst_cnt;
    logic [31:0]  rd_burst_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int lat, beats, bcyc, span, firstv, unstable;
    logic [127:0] got [16];
    bit both_seen = 1'b0;

    uifdma_ram_resp dut (
        .ui_clk      (clk),
        .ui_rstn     (rstn),
        .fdma_waddr  (fdma_waddr),
        .fdma_wareq  (fdma_wareq),
        .fdma_wsize  (fdma_wsize),
        .fdma_wbusy  (fdma_wbusy),
        .fdma_wdata  (fdma_wdata),
        .fdma_wvalid (fdma_wvalid),
        .fdma_wready (fdma_wready),
        .fdma_raddr  (fdma_raddr),
        .fdma_rareq  (fdma_rareq),
        .fdma_rsize  (fdma_rsize),
        .fdma_rbusy  (fdma_rbusy),
        .fdma_rdata  (fdma_rdata),
        .fdma_rvalid (fdma_rvalid),
        .fdma_rready (fdma_rready),
        .wr_burst_cnt(wr_burst_cnt),
        .rd_burst_cnt(rd_burst_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fdma_wbusy && fdma_rbusy) both_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [15:0] n,
                            input logic [127:0] d0);
        int c, first, last;
        logic xfer;
        fdma_waddr  = a;
        fdma_wsize  = n;
        fdma_wdata  = d0;
        fdma_wready = 1'b1;
        fdma_wareq  = 1'b1;
        lat = 0;
        while (!fdma_wbusy && lat < 10) begin
            tick();
            lat++;
        end
        fdma_wareq = 1'b0;
        beats = 0;
        bcyc = int'(fdma_wbusy);
        first = -1;
        last = -1;
        c = 0;
        while (fdma_wbusy && c < 300) begin
            xfer = fdma_wvalid && fdma_wready;
            if (xfer) begin
                beats++;
                if (first < 0) first = c;
                last = c;
            end
            tick();
            c++;
            if (fdma_wbusy) bcyc++;
            if (xfer) fdma_wdata = fdma_wdata + 128'd1;
        end
        span = (beats > 0) ? last - first + 1 : 0;
    endtask

    task automatic run_read(input bit toggle);
        int c, first, last;
        logic hold;
        logic [127:0] hold_d;
        beats = 0;
        firstv = -1;
        unstable = 0;
        first = -1;
        last = -1;
        hold = 1'b0;
        hold_d = '0;
        c = 0;
        while (fdma_rbusy && c < 300) begin
            fdma_rready = toggle ? (c % 2 == 0) : 1'b1;
            if (hold && (!fdma_rvalid || fdma_rdata !== hold_d))
                unstable++;
            if (fdma_rvalid && firstv < 0) firstv = c;
            if (fdma_rvalid && fdma_rready) begin
                if (beats < 16) got[beats] = fdma_rdata;
                beats++;
                if (first < 0) first = c;
                last = c;
            end
            hold = fdma_rvalid && !fdma_rready;
            hold_d = fdma_rdata;
            tick();
            c++;
        end
        fdma_rready = 1'b0;
        span = (beats > 0) ? last - first + 1 : 0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [15:0] n,
                           input bit toggle);
        fdma_raddr  = a;
        fdma_rsize  = n;
        fdma_rready = 1'b0;
        fdma_rareq  = 1'b1;
        lat = 0;
        while (!fdma_rbusy && lat < 10) begin
            tick();
            lat++;
        end
        fdma_rareq = 1'b0;
        run_read(toggle);
    endtask

    initial begin
        int c;
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();

        chk("rst_wbusy", 128'(fdma_wbusy), 128'(0));
        chk("rst_rbusy", 128'(fdma_rbusy), 128'(0));
        chk("rst_wvalid", 128'(fdma_wvalid), 128'(0));
        chk("rst_rvalid", 128'(fdma_rvalid), 128'(0));
        chk("rst_rdata", fdma_rdata, 128'(0));
        chk("rst_wcnt", 128'(wr_burst_cnt), 128'(0));
        chk("rst_rcnt", 128'(rd_burst_cnt), 128'(0));

        // Write 1..4 at 0x100
        do_write(32'h0000_0100, 16'd4, 128'd1);
        chk("w4_lat", 128'(lat), 128'(1));
        chk("w4_beats", 128'(beats), 128'(4));
        chk("w4_span", 128'(span), 128'(4));
        chk("w4_busy_cyc", 128'(bcyc), 128'(6));
        chk("w4_cnt", 128'(wr_burst_cnt), 128'(1));

        // Read back at full rate
        do_read(32'h0000_0100, 16'd4, 1'b0);
        chk("r4_lat", 128'(lat), 128'(1));
        chk("r4_beats", 128'(beats), 128'(4));
        chk("r4_first", 128'(firstv), 128'(2));
        chk("r4_span", 128'(span), 128'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("r4_d%0d", i), got[i], 128'(i + 1));
        chk("r4_cnt", 128'(rd_burst_cnt), 128'(1));

        // Read 8 with rready toggling
        do_write(32'h0000_0200, 16'd8, 128'h10);
        chk("w8_beats", 128'(beats), 128'(8));
        do_read(32'h0000_0200, 16'd8, 1'b1);
        chk("r8_beats", 128'(beats), 128'(8));
        chk("r8_stable", 128'(unstable), 128'(0));
        for (int i = 0; i < 8; i++)
            chk($sformatf("r8_d%0d", i), got[i], 128'(16 + i));
        chk("r8_wcnt", 128'(wr_burst_cnt), 128'(2));
        chk("r8_rcnt", 128'(rd_burst_cnt), 128'(2));

        // Simultaneous requests from reset
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        fdma_waddr  = 32'h0000_0300;
        fdma_wsize  = 16'd1;
        fdma_wdata  = 128'hA0;
        fdma_wready = 1'b1;
        fdma_raddr  = 32'h0000_0300;
        fdma_rsize  = 16'd1;
        fdma_wareq  = 1'b1;
        fdma_rareq  = 1'b1;
        tick();
        chk("tie1_w_first", 128'({fdma_wbusy, fdma_rbusy}), 128'(2'b10));
        fdma_wareq = 1'b0;
        c = 0;
        while (fdma_wbusy && c < 20) begin
            tick();
            c++;
        end
        chk("tie1_w_done", 128'(fdma_wbusy), 128'(0));
        tick();
        chk("tie1_r_second", 128'({fdma_wbusy, fdma_rbusy}), 128'(2'b01));
        fdma_rareq = 1'b0;
        run_read(1'b0);
        chk("tie1_r_beats", 128'(beats), 128'(1));
        chk("tie1_r_data", got[0], 128'hA0);

        // Both again with size 0: write must win again
        fdma_wsize = 16'd0;
        fdma_rsize = 16'd0;
        fdma_wareq = 1'b1;
        fdma_rareq = 1'b1;
        tick();
        chk("tie2_w_first", 128'({fdma_wbusy, fdma_rbusy}), 128'(2'b10));
        chk("sz0_no_wvalid", 128'(fdma_wvalid), 128'(0));
        fdma_wareq = 1'b0;
        tick();
        chk("sz0_w_1cyc", 128'({fdma_wbusy, fdma_rbusy}), 128'(2'b00));
        chk("sz0_wcnt", 128'(wr_burst_cnt), 128'(2));
        tick();
        chk("tie2_r_second", 128'(fdma_rbusy), 128'(1));
        chk("sz0_no_rvalid", 128'(fdma_rvalid), 128'(0));
        fdma_rareq = 1'b0;
        tick();
        chk("sz0_r_1cyc", 128'(fdma_rbusy), 128'(0));
        chk("sz0_rcnt", 128'(rd_burst_cnt), 128'(2));

        // Wrap: beat index 4094 -> 4094, 4095, 0
        do_write(32'h0000_FFE0, 16'd3, 128'h51);
        chk("wrap_w_beats", 128'(beats), 128'(3));
        do_read(32'h0000_FFEF, 16'd3, 1'b0);
        chk("wrap_r_beats", 128'(beats), 128'(3));
        for (int i = 0; i < 3; i++)
            chk($sformatf("wrap_d%0d", i), got[i], 128'(8'h51 + i));
        do_read(32'h0001_0000, 16'd1, 1'b0);
        chk("wrap_idx0", got[0], 128'h53);
        chk("wrap_wcnt", 128'(wr_burst_cnt), 128'(3));
        chk("wrap_rcnt", 128'(rd_burst_cnt), 128'(4));

        // Reset during an 8-beat read
        fdma_raddr  = 32'h0000_0200;
        fdma_rsize  = 16'd8;
        fdma_rready = 1'b1;
        fdma_rareq  = 1'b1;
        tick();
        chk("mid_rbusy", 128'(fdma_rbusy), 128'(1));
        fdma_rareq = 1'b0;
        repeat (3) tick();
        chk("mid_rvalid", 128'(fdma_rvalid), 128'(1));
        chk("mid_beat2", fdma_rdata, 128'h11);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_rvalid", 128'(fdma_rvalid), 128'(0));
        chk("async_rbusy", 128'(fdma_rbusy), 128'(0));
        chk("async_rdata", fdma_rdata, 128'(0));
        fdma_rready = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_idle", 128'({fdma_wbusy, fdma_rbusy}), 128'(0));
        do_read(32'h0000_0100, 16'd4, 1'b0);
        chk("post_rst_beats", 128'(beats), 128'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("post_rst_d%0d", i), got[i], 128'(i + 1));
        chk("post_rst_rcnt", 128'(rd_burst_cnt), 128'(1));
        chk("post_rst_wcnt", 128'(wr_burst_cnt), 128'(0));

        chk("never_both_busy", 128'(both_seen), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uifdma_ram_resp.md
Name: uifdma_ram_resp

Overview:
- FDMA responder: the slave end of the fdma_w*/fdma_r* request/burst interface that video buffer masters drive.
- Services one write or one read burst at a time against an internal single-port synchronous RAM.
- Used as an on-chip frame store for small video buffers, and as a DDR-free FDMA endpoint in bring-up and simulation.

Parameters:
- AXI_ADDR_WIDTH, 32, width of fdma_waddr/fdma_raddr (byte addresses).
- AXI_DATA_WIDTH, 128, beat width in bits; power of two, at least 32.
- MEM_DEPTH, 4096, RAM depth in beats; power of two.

Ports:
- ui_clk  input  1  single clock for all logic.
- ui_rstn  input  1  reset, asynchronous, active low.
- fdma_waddr  input  AXI_ADDR_WIDTH  write burst start byte address.
- fdma_wareq  input  1  write request.
- fdma_wsize  input  16  write burst length in beats.
- fdma_wbusy  output  1  write burst in progress.
- fdma_wdata  input  AXI_DATA_WIDTH  write beat data.
- fdma_wvalid  output  1  responder ready to take a write beat.
- fdma_wready  input  1  master presents valid fdma_wdata.
- fdma_raddr  input  AXI_ADDR_WIDTH  read burst start byte address.
- fdma_rareq  input  1  read request.
- fdma_rsize  input  16  read burst length in beats.
- fdma_rbusy  output  1  read burst in progress.
- fdma_rdata  output  AXI_DATA_WIDTH  read beat data.
- fdma_rvalid  output  1  fdma_rdata valid.
- fdma_rready  input  1  master accepts the read beat.
- wr_burst_cnt  output  32  count of completed write bursts.
- rd_burst_cnt  output  32  count of completed read bursts.

Behaviour:
- Clock and reset: one clock, ui_clk. Reset ui_rstn is asynchronous, active low.
- Reset values: all outputs 0, FSM in IDLE, priority flag = read-last (so write wins first), output buffer empty. RAM contents are not reset.
- Address mapping: beat index = (addr >> log2(AXI_DATA_WIDTH/8)) mod MEM_DEPTH. Low byte-offset bits are ignored. Index wraps from MEM_DEPTH-1 to 0 inside a burst.
- FSM states: IDLE, WBURST, RBURST, DONE.
- IDLE:
  - Samples fdma_wareq and fdma_rareq.
  - Only one asserted: accept it.
  - Both asserted: serve the direction not served last, then toggle the flag.
  - On accept: latch addr and size, and set the matching busy on the next edge (1-cycle request-to-busy latency).
  - Size 0: go straight to DONE; busy is high for exactly 1 cycle and no beats transfer.
- WBURST:
  - fdma_wvalid = 1 while beats remain.
  - A beat transfers on a cycle with fdma_wvalid && fdma_wready: RAM written at the current index, index+1, remaining-1.
  - On the last transfer, fdma_wvalid drops on the next edge and the FSM goes to DONE.
- RBURST:
  - RAM read latency is 1 cycle. A 2-entry output buffer gives full throughput under backpressure.
  - A RAM read issues while beats remain to issue and (buffer occupancy + reads in flight) < 2.
  - fdma_rvalid = buffer non-empty. fdma_rdata is the buffer head and is held stable while fdma_rvalid && !fdma_rready.
  - Peak rate 1 beat/cycle; first fdma_rvalid 2 cycles after busy rises.
  - The FSM goes to DONE when the last beat is popped.
- DONE (1 cycle):
  - Busy drops on the exit edge.
  - The matching burst counter increments (wraps at 2^32).
  - Return to IDLE.
- Request rules:
  - The master holds the request until it sees busy, then deasserts it.
  - Requests are ignored outside IDLE.
  - A request still high in IDLE after DONE is treated as a new request.
  - Minimum gap between busy fall and the next busy rise is 1 cycle.
- fdma_wbusy and fdma_rbusy are never high together.
- Reset mid-burst: the burst is abandoned, outputs are forced to reset values immediately, and RAM writes already done persist.
- Size width: 16-bit sizes; maximum 65535 beats (wraps the RAM when larger than MEM_DEPTH).

Optional Feature:
- Macro: UIFDMA_RESP_STALL_EN.
- Defined:
  - An 8-bit LFSR (taps 8,6,5,4, seed 8'hA5, reset to seed) advances every cycle.
  - When lfsr[0]==0: fdma_wvalid is forced low that cycle, and no new RAM read issues that cycle.
  - Already-asserted fdma_rvalid/fdma_rdata are never withdrawn.
  - Data and order are unchanged; only throughput drops.
- Undefined: no LFSR; full-rate behaviour as above.

Test Plan:
- Write addr 32'h0000_0100, size 4, data 1,2,3,4, wready held high -> wbusy rises 1 cycle after wareq; 4 consecutive wvalid&&wready beats; wbusy high 6 cycles total; wr_burst_cnt=1.
- Read addr 32'h0000_0100, size 4, rready high -> rdata 1,2,3,4 on 4 consecutive cycles, first rvalid 2 cycles after rbusy; rd_burst_cnt=1.
- Read size 8 with rready toggling 1,0,1,0 -> no lost or duplicated beat; rdata stable on every rvalid&&!rready cycle; 8 beats in order.
- wareq and rareq asserted in the same cycle from reset -> write served first, read second; then both again -> write first again, since toggle after the read makes write next.
- Write size 3 at beat index MEM_DEPTH-2 -> beats land at MEM_DEPTH-2, MEM_DEPTH-1, 0; readback confirms. Size 0 request -> busy high 1 cycle, no valid, counter +1.
- ui_rstn pulsed low during beat 2 of an 8-beat read -> rvalid/rbusy go low asynchronously; after release the FSM is in IDLE and a new request completes normally.
